// File: rtl/z_result_drain_if.sv
// Handshake bundle between the ALU result producer and the z_result_drain stage.
// Slave modport is the drain stage; master modport is whoever drives results/consumes beats.
interface z_result_drain_if #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4,
  parameter int CNT_W  = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTL_W-1:0]  in_ctl;
  logic [DATA_W-1:0] z_hi;
  logic [DATA_W-1:0] z_lo;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_is_hi;
  logic              out_last;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  wide_cnt;

  modport slave (
    input  flush, in_valid, in_ctl, z_hi, z_lo, out_ready,
    output in_ready, out_valid, out_data, out_is_hi, out_last, hi_q, lo_q, wide_cnt
  );

  modport master (
    output flush, in_valid, in_ctl, z_hi, z_lo, out_ready,
    input  in_ready, out_valid, out_data, out_is_hi, out_last, hi_q, lo_q, wide_cnt
  );
endinterface

// File: rtl/z_result_drain.sv
// Captures an ALU {hi,lo} result, updates HI/LO on mul/div, drains it as LO[,HI] bus beats.
// Latency: accept at edge N -> beat valid from N+1; backpressure freezes the beat, in_ready only opens on the last beat.
module z_result_drain #(
  parameter int DATA_W   = 32,
  parameter int CTL_W    = 4,
  parameter int MUL_CODE = 3,
  parameter int DIV_CODE = 4,
  parameter int CNT_W    = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  z_result_drain_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] cap_hi;
  logic              cap_wide;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_is_hi_q;
  logic              out_last_q;
  logic [DATA_W-1:0] hi_q_r;
  logic [DATA_W-1:0] lo_q_r;
  logic [CNT_W-1:0]  wide_cnt_r;

  logic is_wide;
  logic is_nop;
  logic accept;
  logic beat_done;

  assign is_wide   = (bus.in_ctl == CTL_W'(MUL_CODE)) || (bus.in_ctl == CTL_W'(DIV_CODE));
  assign is_nop    = (bus.in_ctl == '0);
  // Accepting on the final beat's handshake keeps back-to-back results bubble-free.
  assign bus.in_ready = !bus.flush &&
                        ((state == IDLE) || (out_valid_q && out_last_q && bus.out_ready));
  assign accept    = bus.in_valid && bus.in_ready;
  assign beat_done = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_is_hi = out_is_hi_q;
  assign bus.out_last  = out_last_q;
  assign bus.hi_q      = hi_q_r;
  assign bus.lo_q      = lo_q_r;
  assign bus.wide_cnt  = wide_cnt_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cap_hi      <= '0;
      cap_wide    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_is_hi_q <= 1'b0;
      out_last_q  <= 1'b0;
      hi_q_r      <= '0;
      lo_q_r      <= '0;
      wide_cnt_r  <= '0;
    end else if (bus.flush) begin
      // Architectural HI/LO and the counter survive a flush; only the pending transfer is dropped.
      state       <= IDLE;
      cap_hi      <= '0;
      cap_wide    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_is_hi_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      if (is_wide) begin
        hi_q_r     <= bus.z_hi;
        lo_q_r     <= bus.z_lo;
        wide_cnt_r <= wide_cnt_r + CNT_W'(1);
      end
      if (is_nop) begin
        state       <= IDLE;
        cap_hi      <= '0;
        cap_wide    <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_is_hi_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        state       <= SEND_LO;
        cap_hi      <= bus.z_hi;
        cap_wide    <= is_wide;
        out_valid_q <= 1'b1;
        out_data_q  <= bus.z_lo;
        out_is_hi_q <= 1'b0;
        out_last_q  <= !is_wide;
      end
    end else if (beat_done) begin
      if ((state == SEND_LO) && cap_wide) begin
        state       <= SEND_HI;
        out_data_q  <= cap_hi;
        out_is_hi_q <= 1'b1;
        out_last_q  <= 1'b1;
      end else begin
        state       <= IDLE;
        cap_hi      <= '0;
        cap_wide    <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_is_hi_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_z_result_drain.sv
// Bench for z_result_drain: directed scenarios plus random traffic against a beat-queue model.
module tb_z_result_drain;

  localparam int DATA_W = 32;
  localparam int CTL_W  = 4;
  localparam int CNT_W  = 8;

  logic clock;
  logic reset_n;

  z_result_drain_if #(.DATA_W(DATA_W), .CTL_W(CTL_W), .CNT_W(CNT_W)) bus ();

  z_result_drain #(
    .DATA_W(DATA_W), .CTL_W(CTL_W), .MUL_CODE(3), .DIV_CODE(4), .CNT_W(CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        is_hi;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [7:0]  m_cnt;

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = '0;
  endtask

  task automatic drive(input logic fl, input logic vld, input logic [3:0] ctl,
                       input logic [31:0] hi, input logic [31:0] lo, input logic rdy);
    bus.flush     = fl;
    bus.in_valid  = vld;
    bus.in_ctl    = ctl;
    bus.z_hi      = hi;
    bus.z_lo      = lo;
    bus.out_ready = rdy;
  endtask

  // Compare outputs with the model, then advance the model across the coming edge.
  task automatic cycle();
    logic exp_in_ready;
    logic wide;
    @(negedge clock);
    exp_in_ready = !bus.flush && ((exp_q.size() == 0) || (exp_q.size() == 1 && bus.out_ready));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_data",  bus.out_data,       exp_q[0].data);
      chk("out_is_hi", 32'(bus.out_is_hi), 32'(exp_q[0].is_hi));
      chk("out_last",  32'(bus.out_last),  32'(exp_q[0].last));
    end
    chk("in_ready", 32'(bus.in_ready), 32'(exp_in_ready));
    chk("hi_q",     bus.hi_q,          m_hi);
    chk("lo_q",     bus.lo_q,          m_lo);
    chk("wide_cnt", 32'(bus.wide_cnt), 32'(m_cnt));
    if (bus.flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && exp_in_ready) begin
        wide = (bus.in_ctl == 4'd3) || (bus.in_ctl == 4'd4);
        if (wide) begin
          m_hi  = bus.z_hi;
          m_lo  = bus.z_lo;
          m_cnt = m_cnt + 8'd1;
          exp_q.push_back('{data: bus.z_lo, is_hi: 1'b0, last: 1'b0});
          exp_q.push_back('{data: bus.z_hi, is_hi: 1'b1, last: 1'b1});
        end else if (bus.in_ctl != 4'd0) begin
          exp_q.push_back('{data: bus.z_lo, is_hi: 1'b0, last: 1'b1});
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #12;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data",  bus.out_data,       32'd0);
    chk("rst out_last",  32'(bus.out_last),  32'd0);
    chk("rst in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst wide_cnt",  32'(bus.wide_cnt),  32'd0);
    do_reset();

    // Narrow single beat.
    drive(1'b0, 1'b1, 4'd1, 32'h0, 32'h5, 1'b1); cycle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1); cycle();
    cycle();
    chk("narrow hi_q", bus.hi_q, 32'h0);

    // Wide mul: LO then HI.
    drive(1'b0, 1'b1, 4'd3, 32'h1, 32'hFFFF_FFFE, 1'b1); cycle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1); cycle();
    cycle();
    cycle();
    chk("wide lo_q", bus.lo_q, 32'hFFFF_FFFE);
    chk("wide cnt",  32'(bus.wide_cnt), 32'd1);

    // Backpressure on a divide.
    drive(1'b0, 1'b1, 4'd4, 32'h0000_0007, 32'h0000_0003, 1'b0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'($urandom_range(1, 15)), $urandom, $urandom, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1); cycle();
    cycle();
    cycle();

    // Back-to-back narrow results.
    drive(1'b0, 1'b1, 4'd9,  32'h0, 32'h9, 1'b1); cycle();
    drive(1'b0, 1'b1, 4'd10, 32'h0, 32'hA, 1'b1); cycle();
    drive(1'b0, 1'b0, 4'd0,  32'h0, 32'h0, 1'b1); cycle();
    cycle();

    // Flush during SEND_HI, then a no-op.
    drive(1'b0, 1'b1, 4'd3, 32'hA, 32'hB, 1'b1); cycle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1); cycle();
    drive(1'b1, 1'b1, 4'd1, 32'h0, 32'h77, 1'b0); cycle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1); cycle();
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush hi_q", bus.hi_q, 32'hA);
    drive(1'b0, 1'b1, 4'd0, 32'h1234, 32'h5678, 1'b1); cycle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1); cycle();

    // 256 wide ops wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, (i % 2 == 0) ? 4'd3 : 4'd4, $urandom, $urandom, 1'b1);
      cycle();
      drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
      cycle();
    end
    cycle();
    chk("wrap wide_cnt", 32'(bus.wide_cnt), 32'd0);

    // Asynchronous reset in SEND_LO.
    drive(1'b0, 1'b1, 4'd3, 32'hDEAD, 32'hBEEF, 1'b0); cycle();
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst out_data",  bus.out_data,       32'd0);
    chk("arst out_is_hi", 32'(bus.out_is_hi), 32'd0);
    chk("arst hi_q",      bus.hi_q,           32'd0);
    chk("arst wide_cnt",  32'(bus.wide_cnt),  32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ctl;
      ctl = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4)
                                        : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0, ctl,
            $urandom, $urandom, $urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
    cycle();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
